// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin front end that lets NREQ requesters share one
// combinational 32-bit ALU. The winning request drives the ALU operands and
// opcode. The ALU result and zero flag are then captured into a single
// response register that has a valid/ready output handshake.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Once valid is asserted, the payload stays stable until the transfer.
//   The request side is req_valid[i]/req_ready[i]. req_ready is one-hot or zero.
//   req_ready is combinational from req_valid. Requesters must therefore not
//   derive req_valid from req_ready.
//   The response side is rsp_valid/rsp_ready. The register drains and reloads
//   in the same cycle, so a consumer holding rsp_ready high sees one response
//   per cycle.
module alu_share_arb #(
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_ctrl,
  input  logic [32*NREQ-1:0] req_src1,
  input  logic [32*NREQ-1:0] req_src2,
  output logic [3:0]        alu_ctrl,
  output logic [31:0]       alu_src1,
  output logic [31:0]       alu_src2,
  input  logic [31:0]       alu_res,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_res,
  output logic              rsp_zero
);

  // rr_ptr holds the most recent winner. The scan starts one past it.
  logic [IDW-1:0] rr_ptr;
  logic           slot_free;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic           grant_en;
  logic [IDW-1:0] cand;

  // The register can take a new result when it is empty or being drained now.
  assign slot_free = !rsp_valid || rsp_ready;

  // Round-robin scan: first valid requester at rr_ptr+1, rr_ptr+2, ... mod NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // No grant is made during reset, so an in-flight request is not accepted.
  assign grant_en = grant_found && slot_free && !rst;

  // Drive the ready strobe and the ALU inputs from the winner. With no winner,
  // the ALU sees ADD of zero operands.
  always_comb begin
    req_ready = '0;
    alu_ctrl  = 4'b0000;
    alu_src1  = 32'd0;
    alu_src2  = 32'd0;
    if (grant_en) begin
      req_ready[grant_id] = 1'b1;
      alu_ctrl            = req_ctrl[4*grant_id +: 4];
      alu_src1            = req_src1[32*grant_id +: 32];
      alu_src2            = req_src2[32*grant_id +: 32];
    end
  end

  // Response register and arbitration pointer.
  // A drain without a reload clears only rsp_valid. The data fields keep
  // their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= 32'd0;
      rsp_zero  <= 1'b0;
      rr_ptr    <= IDW'(NREQ - 1);
    end else if (grant_en) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_id;
      rsp_res   <= alu_res;
      rsp_zero  <= alu_zero;
      rr_ptr    <= grant_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // At most one requester is told it was accepted in any cycle.
  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  // A stalled response keeps its contents until it is taken.
  a_stall_stable : assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_res) &&
                                   $stable(rsp_id) && $stable(rsp_zero)));

  // A full register that is not draining blocks every request.
  a_stall_block : assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |-> (req_ready == '0));

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: bench for alu_share_arb.
// It instantiates one NREQ=2 and one NREQ=3 instance, each attached to a
// bench-side ALU model. A reference arbiter model predicts every grant. The
// predicted results go into per-instance expected queues, and each queue is
// checked against the response register every cycle.
module tb_alu_share_arb;

  typedef logic [34:0] item_t;  // {id[1:0], zero, res[31:0]}

  typedef struct {
    int          who;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  logic clk;
  logic rst;

  // Instance A (NREQ=2)
  logic [1:0]  a_valid, a_req_ready;
  logic [7:0]  a_ctrl;
  logic [63:0] a_src1, a_src2;
  logic [3:0]  a_alu_ctrl;
  logic [31:0] a_alu_src1, a_alu_src2, a_alu_res, a_rsp_res;
  logic        a_alu_zero, a_rsp_valid, a_rsp_ready, a_rsp_zero;
  logic [0:0]  a_rsp_id;

  // Instance B (NREQ=3)
  logic [2:0]  b_valid, b_req_ready;
  logic [11:0] b_ctrl;
  logic [95:0] b_src1, b_src2;
  logic [3:0]  b_alu_ctrl;
  logic [31:0] b_alu_src1, b_alu_src2, b_alu_res, b_rsp_res;
  logic        b_alu_zero, b_rsp_valid, b_rsp_ready, b_rsp_zero;
  logic [1:0]  b_rsp_id;

  // Scoreboards and reference-model state
  item_t exp_q_a[$];
  item_t exp_q_b[$];
  logic  ma_valid, mb_valid;
  int    ma_ptr, mb_ptr;
  item_t ma_last, mb_last;

  int errors = 0;
  int checks = 0;

  vec_t  vecs[10];
  item_t snap;
  int    ids_b[7];

  // Bench ALU: the opcode map the parent would instantiate
  function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] x, logic [31:0] y);
    case (c)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0010: return x & y;
      4'b0011: return x | y;
      4'b0100: return x ^ y;
      4'b0101: return x << y[4:0];
      4'b1000: return x >> y[4:0];
      4'b1001: return 32'($signed(x) >>> y[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int pick(int n, int ptr, logic [2:0] v);
    for (int k = 1; k <= n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  assign a_alu_res  = alu_f(a_alu_ctrl, a_alu_src1, a_alu_src2);
  assign a_alu_zero = (a_alu_res == 32'd0);
  assign b_alu_res  = alu_f(b_alu_ctrl, b_alu_src1, b_alu_src2);
  assign b_alu_zero = (b_alu_res == 32'd0);

  alu_share_arb #(.NREQ(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_req_ready), .req_ctrl(a_ctrl),
    .req_src1(a_src1), .req_src2(a_src2),
    .alu_ctrl(a_alu_ctrl), .alu_src1(a_alu_src1), .alu_src2(a_alu_src2),
    .alu_res(a_alu_res), .alu_zero(a_alu_zero),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
    .rsp_res(a_rsp_res), .rsp_zero(a_rsp_zero)
  );

  alu_share_arb #(.NREQ(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_req_ready), .req_ctrl(b_ctrl),
    .req_src1(b_src1), .req_src2(b_src2),
    .alu_ctrl(b_alu_ctrl), .alu_src1(b_alu_src1), .alu_src2(b_alu_src2),
    .alu_res(b_alu_res), .alu_zero(b_alu_zero),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_res(b_rsp_res), .rsp_zero(b_rsp_zero)
  );

  // Clock: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [99:0] act, logic [99:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive_a(int i, logic [3:0] c, logic [31:0] x, logic [31:0] y);
    a_ctrl[4*i +: 4]  = c;
    a_src1[32*i +: 32] = x;
    a_src2[32*i +: 32] = y;
  endtask

  task automatic drive_b(int i, logic [3:0] c, logic [31:0] x, logic [31:0] y);
    b_ctrl[4*i +: 4]  = c;
    b_src1[32*i +: 32] = x;
    b_src2[32*i +: 32] = y;
  endtask

  task automatic model_reset();
    exp_q_a.delete(); exp_q_b.delete();
    ma_valid = 1'b0; mb_valid = 1'b0;
    ma_ptr = 1; mb_ptr = 2;
    ma_last = '0; mb_last = '0;
  endtask

  // One clock cycle. Inputs are already set. The task checks both instances
  // at mid-cycle, advances the models, and returns 1 ns after the edge.
  task automatic step();
    int ga, gb;
    logic [31:0] r;
    item_t it;
    #4;
    // Instance A
    ga = (!rst && (!ma_valid || a_rsp_ready)) ? pick(2, ma_ptr, {1'b0, a_valid}) : -1;
    chk("a_req_ready", a_req_ready, (ga >= 0) ? (100'd1 << ga) : 100'd0);
    chk("a_alu_in", {a_alu_ctrl, a_alu_src1, a_alu_src2},
        (ga >= 0) ? {a_ctrl[4*ga +: 4], a_src1[32*ga +: 32], a_src2[32*ga +: 32]} : 100'd0);
    chk("a_rsp_valid", a_rsp_valid, ma_valid);
    if (ma_valid) begin
      if (exp_q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_queue got=empty exp=entry");
      end else begin
        chk("a_rsp_data", {1'b0, a_rsp_id, a_rsp_zero, a_rsp_res}, exp_q_a[0]);
      end
    end else begin
      chk("a_rsp_hold", {1'b0, a_rsp_id, a_rsp_zero, a_rsp_res}, ma_last);
    end
    // Instance B
    gb = (!rst && (!mb_valid || b_rsp_ready)) ? pick(3, mb_ptr, b_valid) : -1;
    chk("b_req_ready", b_req_ready, (gb >= 0) ? (100'd1 << gb) : 100'd0);
    chk("b_alu_in", {b_alu_ctrl, b_alu_src1, b_alu_src2},
        (gb >= 0) ? {b_ctrl[4*gb +: 4], b_src1[32*gb +: 32], b_src2[32*gb +: 32]} : 100'd0);
    chk("b_rsp_valid", b_rsp_valid, mb_valid);
    if (mb_valid) begin
      if (exp_q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_queue got=empty exp=entry");
      end else begin
        chk("b_rsp_data", {b_rsp_id, b_rsp_zero, b_rsp_res}, exp_q_b[0]);
      end
    end else begin
      chk("b_rsp_hold", {b_rsp_id, b_rsp_zero, b_rsp_res}, mb_last);
    end
    // Advance the models
    if (rst) begin
      model_reset();
    end else begin
      if (ma_valid && a_rsp_ready) void'(exp_q_a.pop_front());
      if (ga >= 0) begin
        r = alu_f(a_ctrl[4*ga +: 4], a_src1[32*ga +: 32], a_src2[32*ga +: 32]);
        it = {2'(ga), (r == 32'd0), r};
        exp_q_a.push_back(it);
        ma_last = it; ma_valid = 1'b1; ma_ptr = ga;
      end else if (a_rsp_ready) begin
        ma_valid = 1'b0;
      end
      if (mb_valid && b_rsp_ready) void'(exp_q_b.pop_front());
      if (gb >= 0) begin
        r = alu_f(b_ctrl[4*gb +: 4], b_src1[32*gb +: 32], b_src2[32*gb +: 32]);
        it = {2'(gb), (r == 32'd0), r};
        exp_q_b.push_back(it);
        mb_last = it; mb_valid = 1'b1; mb_ptr = gb;
      end else if (b_rsp_ready) begin
        mb_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ops[9];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd15};

    // Table of single-op vectors: {who, opcode, a, b, result, zero}
    vecs[0] = '{0, 4'b0000, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1] = '{1, 4'b0001, 32'd9,        32'd9,        32'd0,        1'b1};
    vecs[2] = '{1, 4'b1001, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vecs[3] = '{0, 4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[4] = '{1, 4'b0011, 32'h00000001, 32'h80000000, 32'h80000001, 1'b0};
    vecs[5] = '{0, 4'b0100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1};
    vecs[6] = '{0, 4'b0101, 32'd1,        32'd31,       32'h80000000, 1'b0};
    vecs[7] = '{1, 4'b1000, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
    vecs[8] = '{0, 4'b1111, 32'd123,      32'd456,      32'h00000000, 1'b1};
    vecs[9] = '{1, 4'b0000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1};

    // Reset
    rst = 1'b1;
    a_valid = '0; a_ctrl = '0; a_src1 = '0; a_src2 = '0; a_rsp_ready = 1'b1;
    b_valid = '0; b_ctrl = '0; b_src1 = '0; b_src2 = '0; b_rsp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", {a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_res}, 100'd0);
    step();

    // Table vectors, issued back to back on instance A
    for (int v = 0; v < 10; v++) begin
      a_valid = '0;
      a_valid[vecs[v].who] = 1'b1;
      drive_a(vecs[v].who, vecs[v].ctrl, vecs[v].a, vecs[v].b);
      step();
      chk($sformatf("vec%0d", v), {a_rsp_valid, 2'(a_rsp_id), a_rsp_zero, a_rsp_res},
          {1'b1, 2'(vecs[v].who), vecs[v].zero, vecs[v].res});
    end
    a_valid = '0;
    step();

    // Both requesters valid every cycle: grants alternate
    a_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      drive_a(0, ops[$urandom_range(0, 8)], $urandom, $urandom);
      drive_a(1, ops[$urandom_range(0, 8)], $urandom, $urandom);
      step();
    end

    // Stall for 3 cycles, then release: drain and accept in the same cycle
    a_rsp_ready = 1'b0;
    snap = {1'b0, a_rsp_id, a_rsp_zero, a_rsp_res};
    repeat (3) step();
    chk("stall_frozen", {a_rsp_valid, 1'b0, a_rsp_id, a_rsp_zero, a_rsp_res}, {1'b1, snap});
    a_rsp_ready = 1'b1;
    step();
    step();
    a_valid = '0;
    step();

    // Random traffic on both instances
    for (int c = 0; c < 300; c++) begin
      a_valid = 2'($urandom_range(0, 3));
      b_valid = 3'($urandom_range(0, 7));
      a_rsp_ready = ($urandom_range(0, 3) != 0);
      b_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) drive_a(i, ops[$urandom_range(0, 8)], $urandom, $urandom_range(0, 40));
      for (int i = 0; i < 3; i++) drive_b(i, ops[$urandom_range(0, 8)], $urandom, $urandom_range(0, 40));
      step();
    end

    // Reset while holding a stalled response
    a_valid = 2'b11; b_valid = '0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clear", a_rsp_valid, 1'b0);
    a_rsp_ready = 1'b1;
    step();
    chk("rst_first_id", {a_rsp_valid, a_rsp_id}, {1'b1, 1'b0});
    a_valid = '0;
    step();

    // NREQ=3: requesters 0 and 2 alternate, then requester 1 joins
    ids_b = '{0, 2, 0, 2, 0, 1, 2};
    b_valid = 3'b101;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) b_valid = 3'b111;
      for (int i = 0; i < 3; i++) drive_b(i, 4'b0000, 32'(c), 32'(i));
      step();
      chk($sformatf("b_grant%0d", c), {b_rsp_valid, b_rsp_id}, {1'b1, 2'(ids_b[c])});
    end
    b_valid = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
